// File: rtl/mem_pkg.sv
// Shared size codes, FSM encoding and latched-request layout for the memory access path.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    // Accesses that must be rejected without touching memory.
    function automatic logic bad_access(input logic [1:0] size, input logic [1:0] a);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = a[0];
            SZ_WORD: bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering: merges sub-word store data into a word and extracts/extends load data.
module mem_lane
    import mem_pkg::*;
#(
    parameter bit LITTLE = 1'b1
) (
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [31:0] ext
);

    // wb[i] is the byte at address offset i, independent of byte order.
    logic [NUM_LANES-1:0][VEC_W-1:0] wb;
    logic [7:0]  b;
    logic [15:0] h;

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            localparam int         P  = LITTLE ? i : NUM_LANES - 1 - i;
            localparam logic [1:0] A  = 2'(i);
            localparam bit         HI = (A[0] == LITTLE);

            logic       en;
            logic [7:0] sb;

            assign wb[i] = word[VEC_W*P +: VEC_W];

            always_comb begin
                en = 1'b1;
                sb = wdata[VEC_W*P +: VEC_W];
                case (size)
                    SZ_BYTE: begin
                        en = (addr == A);
                        sb = wdata[7:0];
                    end
                    SZ_HALF: begin
                        en = (addr[1] == A[1]);
                        sb = HI ? wdata[15:8] : wdata[7:0];
                    end
                    default: ;
                endcase
            end

            assign merged[VEC_W*P +: VEC_W] = en ? sb : wb[i];
        end
    endgenerate

    always_comb begin
        b = wb[addr];
        if (LITTLE)
            h = {wb[{addr[1], 1'b1}], wb[{addr[1], 1'b0}]};
        else
            h = {wb[{addr[1], 1'b0}], wb[{addr[1], 1'b1}]};
    end

    always_comb begin
        ext = word;
        case (size)
            SZ_BYTE: ext = {{24{sign & b[7]}}, b};
            SZ_HALF: ext = {{16{sign & h[15]}}, h};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: read-modify-write for sub-word stores, extending loads, ack watchdog.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter bit LITTLE  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t        state, state_nxt;
    acc_t          cur;
    logic [31:0]   rword;
    logic [CW-1:0] wdog;
    logic          tmo;
    logic [31:0]   lane_word, lane_merged, lane_ext;

    // In RD the lane sees the live read word so the load result is ready on the ack edge.
    assign lane_word = (state == RD) ? mem_rdata : rword;

    mem_lane #(.LITTLE(LITTLE)) u_lane (
        .word   (lane_word),
        .addr   (cur.addr[1:0]),
        .size   (cur.size),
        .sign   (cur.sign),
        .wdata  (cur.wdata),
        .merged (lane_merged),
        .ext    (lane_ext)
    );

    assign tmo = (TIMEOUT != 0) && (wdog == CW'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (bad_access(size, addr[1:0]))
                        state_nxt = ERR;
                    else if (we && size == SZ_WORD)
                        state_nxt = WR;
                    else
                        state_nxt = RD;
                end
            end
            RD: begin
                if (mem_ack)
                    state_nxt = cur.we ? WR : DONE;
                else if (tmo)
                    state_nxt = ERR;
            end
            WR: begin
                if (mem_ack)
                    state_nxt = DONE;
                else if (tmo)
                    state_nxt = ERR;
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cur   <= '0;
            rword <= '0;
            rdata <= '0;
            wdog  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req)
                cur <= '{we: we, size: size, sign: sign, addr: addr, wdata: wdata};
            if (state == RD && mem_ack) begin
                rword <= mem_rdata;
                if (!cur.we)
                    rdata <= lane_ext;
            end
            // Each memory phase gets a fresh budget, including the RD->WR hop.
            if (state_nxt != state)
                wdog <= '0;
            else if ((state == RD || state == WR) && !mem_ack)
                wdog <= wdog + CW'(1);
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE) || (state == ERR);
    assign err       = (state == ERR);
    assign mem_req   = (state == RD) || (state == WR);
    assign mem_we    = (state == WR);
    assign mem_addr  = {cur.addr[31:2], 2'b00};
    assign mem_wdata = lane_merged;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word-memory responder of programmable ack delay.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err, mem_req, mem_we, mem_ack;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    int ack_dly = 2;
    bit ack_en  = 1'b1;

    logic [31:0] mem [0:1023];
    int          cnt = 0;
    int          nrd = 0;
    int          nwr = 0;
    int          mreq_cyc = 0;
    logic [31:0] last_w = '0;
    logic [31:0] last_wa = '0;

    mem_access_unit #(.TIMEOUT(4), .LITTLE(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .size      (size),
        .sign      (sign),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    assign mem_ack   = ack_en && mem_req && (cnt == ack_dly);
    assign mem_rdata = mem[mem_addr[11:2]];

    // Memory contents reload whenever reset is held.
    always @(posedge clk) begin
        if (!rst) begin
            mem[10'h040] <= 32'h8899_AABB;
            mem[10'h080] <= 32'h0000_0000;
            mem[10'h0C0] <= 32'h1122_3344;
            mem[10'h100] <= 32'h1122_3344;
            cnt          <= 0;
        end else begin
            if (!mem_req || mem_ack) cnt <= 0;
            else                     cnt <= cnt + 1;
            if (mem_req && mem_ack && mem_we)
                mem[mem_addr[11:2]] <= mem_wdata;
        end
    end

    always @(posedge clk) begin
        if (mem_req) mreq_cyc <= mreq_cyc + 1;
        if (mem_req && mem_ack) begin
            if (mem_we) begin
                nwr     <= nwr + 1;
                last_w  <= mem_wdata;
                last_wa <= mem_addr;
            end else begin
                nrd <= nrd + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one access; lat counts cycles from the req edge to the cycle where done is seen.
    task automatic access(input bit w, input logic [1:0] s, input bit sg,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er,
                          output logic seen);
        @(negedge clk);
        req = 1'b1; we = w; size = s; sign = sg; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0; we = ~w; size = ~s; sign = ~sg; addr = ~a; wdata = ~d;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        seen = done;
        rd   = rdata;
        er   = err;
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er, seen;
        int          r0, w0, m0, nd, nidle;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {27'd0, busy, done, err, mem_req, mem_we}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_mwdata", mem_wdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Loads from 0x100 = 8899_AABB, ack two cycles after mem_req
        ack_dly = 2;
        r0 = nrd;
        access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, lat, rd, er, seen);
        chk("lb_done", {31'd0, seen}, 32'd1);
        chk("lb", rd, 32'hFFFF_FF88);
        chk("lb_lat", lat, 4);
        chk("lb_err", {31'd0, er}, 32'd0);
        access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, lat, rd, er, seen);
        chk("lbu", rd, 32'h0000_0088);
        access(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, lat, rd, er, seen);
        chk("lh", rd, 32'hFFFF_AABB);
        access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, lat, rd, er, seen);
        chk("lhu", rd, 32'h0000_8899);
        chk("load_reads", nrd - r0, 4);

        // Sub-word stores: read-modify-write
        r0 = nrd; w0 = nwr;
        access(1'b1, 2'b00, 1'b0, 32'h301, 32'hDEAD_BEEF, lat, rd, er, seen);
        chk("sb_lat", lat, 7);
        chk("sb_word", last_w, 32'h1122_EF44);
        chk("sb_addr", last_wa, 32'h300);
        chk("sb_rd_cnt", nrd - r0, 1);
        chk("sb_wr_cnt", nwr - w0, 1);
        chk("sb_rdata_kept", rd, 32'h0000_8899);
        access(1'b1, 2'b01, 1'b0, 32'h402, 32'h0000_CAFE, lat, rd, er, seen);
        chk("sh_word", last_w, 32'hCAFE_3344);

        // Word store with immediate ack: no read phase
        ack_dly = 0;
        r0 = nrd; w0 = nwr;
        access(1'b1, 2'b10, 1'b0, 32'h200, 32'h1234_5678, lat, rd, er, seen);
        chk("sw_lat", lat, 2);
        chk("sw_word", last_w, 32'h1234_5678);
        chk("sw_rd_cnt", nrd - r0, 0);
        chk("sw_wr_cnt", nwr - w0, 1);
        access(1'b0, 2'b10, 1'b1, 32'h200, 32'h0, lat, rd, er, seen);
        chk("lw", rd, 32'h1234_5678);
        chk("lw_lat", lat, 2);

        // Misaligned / illegal: immediate error, no memory request
        m0 = mreq_cyc;
        access(1'b0, 2'b01, 1'b1, 32'h101, 32'h0, lat, rd, er, seen);
        chk("mis_lh_lat", lat, 1);
        chk("mis_lh_err", {31'd0, er}, 32'd1);
        chk("mis_lh_rdata", rd, 32'h1234_5678);
        access(1'b1, 2'b10, 1'b0, 32'h202, 32'hFFFF_FFFF, lat, rd, er, seen);
        chk("mis_sw_lat", lat, 1);
        chk("mis_sw_err", {31'd0, er}, 32'd1);
        access(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, lat, rd, er, seen);
        chk("ill_sz_err", {31'd0, er}, 32'd1);
        chk("ill_sz_rdata", rd, 32'h1234_5678);
        chk("mis_no_mreq", mreq_cyc - m0, 0);

        // Watchdog: no ack ever, TIMEOUT=4
        ack_en = 1'b0;
        m0 = mreq_cyc;
        access(1'b0, 2'b00, 1'b1, 32'h100, 32'h0, lat, rd, er, seen);
        chk("tmo_lat", lat, 5);
        chk("tmo_err", {31'd0, er}, 32'd1);
        chk("tmo_mreq_cyc", mreq_cyc - m0, 4);
        chk("tmo_rdata", rd, 32'h1234_5678);
        @(negedge clk);
        chk("tmo_busy", {31'd0, busy}, 32'd0);
        ack_en = 1'b1;

        // Reset while in WR abandons the write
        ack_dly = 3;
        w0 = nwr;
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; sign = 1'b0; addr = 32'h200; wdata = 32'hAAAA_5555;
        @(negedge clk);
        req = 1'b0;
        chk("wr_mreq", {30'd0, mem_req, mem_we}, 32'd3);
        rst = 1'b0;
        @(negedge clk);
        chk("rstwr_ctrl", {29'd0, mem_req, busy, done}, 32'd0);
        rst = 1'b1;
        chk("rstwr_no_write", nwr - w0, 0);

        // req held high: one access per IDLE cycle, period 4 with ack_dly=1
        ack_dly = 1;
        r0 = nrd; nd = 0; nidle = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b00; sign = 1'b0; addr = 32'h103; wdata = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) nd++;
            if (!busy) nidle++;
        end
        req = 1'b0;
        @(negedge clk);
        chk("b2b_done_cnt", nd, 5);
        chk("b2b_reads", nrd - r0, 5);
        chk("b2b_idle_cnt", nidle, 5);
        chk("b2b_rdata", rdata, 32'h0000_0088);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
